// File: rtl/hazard_stall_ctrl.sv
// Hazard and MDU scheduling controller for the 5-stage MIPS pipeline.
// Uses a Tuse/Tnew RAW check and an MDU busy counter to drive FREEZE (PC, IF/ID) and FLUSH_E (ID/EX).
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  output logic        FREEZE,
  output logic        FLUSH_E,
  output logic        MDU_BUSY,
  output logic [31:0] STALL_CNT
);

  localparam int unsigned MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned CW_RAW  = $clog2(MAX_CYC + 1);
  localparam int unsigned CW      = (CW_RAW < 4) ? 4 : CW_RAW;

  typedef struct packed {
    logic       use_rs;
    logic       use_rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] dst;
    logic [1:0] tnew_e;
    logic       tnew_m;
    logic       mdu;
    logic       mul;
    logic       div;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d = '0;
    if (ir[31:26] == 6'h00) begin
      case (ir[5:0])
        6'h21, 6'h23: begin
          d.use_rs = 1'b1; d.use_rt = 1'b1; d.tuse_rs = 2'd1; d.tuse_rt = 2'd1;
          d.dst = ir[15:11]; d.tnew_e = 2'd1;
        end
        6'h08: d.use_rs = 1'b1;
        6'h18, 6'h19, 6'h1A, 6'h1B: begin
          d.use_rs = 1'b1; d.use_rt = 1'b1; d.tuse_rs = 2'd1; d.tuse_rt = 2'd1;
          d.mdu = 1'b1; d.mul = ~ir[1]; d.div = ir[1];
        end
        6'h10, 6'h12: begin
          d.dst = ir[15:11]; d.tnew_e = 2'd1; d.mdu = 1'b1;
        end
        6'h11, 6'h13: begin
          d.use_rs = 1'b1; d.tuse_rs = 2'd1; d.mdu = 1'b1;
        end
        default: d = '0;
      endcase
    end else begin
      case (ir[31:26])
        6'h0D: begin
          d.use_rs = 1'b1; d.tuse_rs = 2'd1; d.dst = ir[20:16]; d.tnew_e = 2'd1;
        end
        6'h0F: begin
          d.dst = ir[20:16]; d.tnew_e = 2'd1;
        end
        6'h23: begin
          d.use_rs = 1'b1; d.tuse_rs = 2'd1; d.dst = ir[20:16];
          d.tnew_e = 2'd2; d.tnew_m = 1'b1;
        end
        6'h2B: begin
          d.use_rs = 1'b1; d.use_rt = 1'b1; d.tuse_rs = 2'd1; d.tuse_rt = 2'd2;
        end
        6'h04: begin
          d.use_rs = 1'b1; d.use_rt = 1'b1;
        end
        6'h03: d.dst = 5'd31;
        default: d = '0;
      endcase
    end
    return d;
  endfunction

  function automatic logic raw(input logic used, input logic [4:0] src, input logic [1:0] tuse,
                               input logic [4:0] dst, input logic [1:0] tnew);
    return used && (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

  dec_t          dec_d, dec_e, dec_m;
  logic          raw_stall, mdu_stall, stall;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic          unused_dec;

  always_comb begin
    dec_d = decode(IR_D);
    dec_e = decode(IR_E);
    dec_m = decode(IR_M);
  end

  // Only destination/Tnew of EX and MEM and the source side of ID matter.
  assign unused_dec = ^{dec_d, dec_e, dec_m, IR_M};

  always_comb begin
    raw_stall = raw(dec_d.use_rs, IR_D[25:21], dec_d.tuse_rs, dec_e.dst, dec_e.tnew_e)
              | raw(dec_d.use_rt, IR_D[20:16], dec_d.tuse_rt, dec_e.dst, dec_e.tnew_e)
              | raw(dec_d.use_rs, IR_D[25:21], dec_d.tuse_rs, dec_m.dst, {1'b0, dec_m.tnew_m})
              | raw(dec_d.use_rt, IR_D[20:16], dec_d.tuse_rt, dec_m.dst, {1'b0, dec_m.tnew_m});
    MDU_BUSY  = (cnt_q != '0) | dec_e.mul | dec_e.div;
    mdu_stall = dec_d.mdu & MDU_BUSY;
    stall     = ~reset & (raw_stall | mdu_stall);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (dec_e.mul)          cnt_d = CW'(MULT_CYC);
    else if (dec_e.div)     cnt_d = CW'(DIV_CYC);
    else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
    stall_cnt_d = stall_cnt_q + 32'(stall);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FREEZE    = stall;
  assign FLUSH_E   = stall;
  assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a vector table of single-cycle hazard cases plus
// hand-written multi-cycle sequences for load-use, MDU busy windows and mid-operation reset.
module tb_hazard_stall_ctrl;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] IR_D = '0, IR_E = '0, IR_M = '0;
  logic        FREEZE, FLUSH_E, MDU_BUSY;
  logic [31:0] STALL_CNT;

  int unsigned n_chk = 0, n_pass = 0;
  logic [31:0] exp_cnt = '0;
  logic [31:0] base;

  typedef struct {
    string       name;
    logic [31:0] d, e, m;
    logic        xs, xb;
  } vec_t;
  vec_t tbl[$];

  hazard_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .CLK(CLK), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M),
    .FREEZE(FREEZE), .FLUSH_E(FLUSH_E), .MDU_BUSY(MDU_BUSY), .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rty(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] ity(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Apply one cycle of pipeline contents, check at negedge, then step past the next posedge.
  task automatic cyc(input string name, input logic rst, input logic [31:0] d, input logic [31:0] e,
                     input logic [31:0] m, input logic xs, input logic xb);
    reset = rst; IR_D = d; IR_E = e; IR_M = m;
    @(negedge CLK);
    chk({name, " FREEZE"},    32'(FREEZE),   32'(xs));
    chk({name, " FLUSH_E"},   32'(FLUSH_E),  32'(xs));
    chk({name, " MDU_BUSY"},  32'(MDU_BUSY), 32'(xb));
    chk({name, " STALL_CNT"}, STALL_CNT,     exp_cnt);
    @(posedge CLK);
    if (rst) exp_cnt = '0;
    else if (xs) exp_cnt = exp_cnt + 32'd1;
    #1;
  endtask

  task automatic add(input string name, input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                     input logic xs, input logic xb);
    vec_t v;
    v.name = name; v.d = d; v.e = e; v.m = m; v.xs = xs; v.xb = xb;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] LW1, LW2, LW0, LW5, BEQ12, BEQ30, BEQ40, ADDU312, ADDU46, SW43, SW35, SW15, SW51;
    logic [31:0] JR0, JR31, JR7, JAL, LUI1, ORI7, ADDI1, MFLO4, MFHI5, MULT, DIV, MTHI;
    LW1 = ity(6'h23, 5'd0, 5'd1);   LW2 = ity(6'h23, 5'd0, 5'd2);
    LW0 = ity(6'h23, 5'd0, 5'd0);   LW5 = ity(6'h23, 5'd0, 5'd5);
    BEQ12 = ity(6'h04, 5'd1, 5'd2); BEQ30 = ity(6'h04, 5'd3, 5'd0); BEQ40 = ity(6'h04, 5'd4, 5'd0);
    ADDU312 = rty(6'h21, 5'd1, 5'd2, 5'd3); ADDU46 = rty(6'h21, 5'd4, 5'd0, 5'd6);
    SW43 = ity(6'h2B, 5'd3, 5'd4);  SW35 = ity(6'h2B, 5'd5, 5'd3);
    SW15 = ity(6'h2B, 5'd5, 5'd1);  SW51 = ity(6'h2B, 5'd1, 5'd5);
    JR0 = rty(6'h08, 5'd0, 5'd0, 5'd0); JR31 = rty(6'h08, 5'd31, 5'd0, 5'd0);
    JR7 = rty(6'h08, 5'd7, 5'd0, 5'd0); JAL = {6'h03, 26'h0000010};
    LUI1 = ity(6'h0F, 5'd0, 5'd1);  ORI7 = ity(6'h0D, 5'd0, 5'd7); ADDI1 = ity(6'h08, 5'd0, 5'd1);
    MFLO4 = rty(6'h12, 5'd0, 5'd0, 5'd4); MFHI5 = rty(6'h10, 5'd0, 5'd0, 5'd5);
    MULT = rty(6'h18, 5'd1, 5'd2, 5'd0);  DIV = rty(6'h1A, 5'd1, 5'd2, 5'd0);
    MTHI = rty(6'h11, 5'd1, 5'd0, 5'd0);

    //   name           ID       EX       MEM   stall busy
    add("nop",          '0,      '0,      '0,   1'b0, 1'b0);
    add("lwE_beq",      BEQ12,   LW1,     '0,   1'b1, 1'b0);
    add("lwM_beq",      BEQ12,   '0,      LW1,  1'b1, 1'b0);
    add("lwM_beq_rt",   BEQ12,   '0,      LW2,  1'b1, 1'b0);
    add("lwE_addu",     ADDU312, LW1,     '0,   1'b1, 1'b0);
    add("lwM_addu",     ADDU312, '0,      LW1,  1'b0, 1'b0);
    add("adduE_sw_rs",  SW43,    ADDU312, '0,   1'b0, 1'b0);
    add("adduE_sw_rt",  SW35,    ADDU312, '0,   1'b0, 1'b0);
    add("adduE_beq",    BEQ30,   ADDU312, '0,   1'b1, 1'b0);
    add("adduM_beq",    BEQ30,   '0,      ADDU312, 1'b0, 1'b0);
    add("lw0_jr0",      JR0,     LW0,     '0,   1'b0, 1'b0);
    add("jalE_jr31",    JR31,    JAL,     '0,   1'b0, 1'b0);
    add("lwE_lui",      LUI1,    LW1,     '0,   1'b0, 1'b0);
    add("oriE_jr",      JR7,     ORI7,    '0,   1'b1, 1'b0);
    add("lwE_sw_base",  SW15,    LW5,     '0,   1'b1, 1'b0);
    add("lwE_sw_data",  SW51,    LW5,     '0,   1'b0, 1'b0);
    add("addiE_beq",    BEQ12,   ADDI1,   '0,   1'b0, 1'b0);
    add("mfloE_addu",   ADDU46,  MFLO4,   '0,   1'b0, 1'b0);
    add("mfloE_beq",    BEQ40,   MFLO4,   '0,   1'b1, 1'b0);
    add("mfhi_idle",    MFHI5,   '0,      '0,   1'b0, 1'b0);

    @(posedge CLK); @(posedge CLK); #1;
    cyc("reset", 1'b1, BEQ12, LW1, '0, 1'b0, 1'b0);
    foreach (tbl[i]) cyc(tbl[i].name, 1'b0, tbl[i].d, tbl[i].e, tbl[i].m, tbl[i].xs, tbl[i].xb);

    // Load-use into a branch: two bubbles.
    base = STALL_CNT;
    cyc("ldbr c1", 1'b0, BEQ12, LW1, '0,  1'b1, 1'b0);
    cyc("ldbr c2", 1'b0, BEQ12, '0,  LW1, 1'b1, 1'b0);
    cyc("ldbr c3", 1'b0, '0,    BEQ12, '0, 1'b0, 1'b0);
    chk("ldbr delta", STALL_CNT - base, 32'd2);

    // mult issue with mflo waiting in ID: frozen cycles 0..5.
    base = STALL_CNT;
    cyc("mul c0", 1'b0, MFLO4, MULT, '0, 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++)
      cyc($sformatf("mul c%0d", k), 1'b0, MFLO4, '0, (k == 1) ? MULT : '0, 1'b1, 1'b1);
    cyc("mul c6", 1'b0, MFLO4, '0, '0, 1'b0, 1'b0);
    cyc("mul c7", 1'b0, '0, MFLO4, '0, 1'b0, 1'b0);
    chk("mul delta", STALL_CNT - base, 32'd6);

    // div busy for 11 cycles; an independent addu flows through.
    base = STALL_CNT;
    cyc("div c0", 1'b0, ADDU312, DIV, '0, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++)
      cyc($sformatf("div c%0d", k), 1'b0, '0, (k == 1) ? ADDU312 : '0,
          (k == 1) ? DIV : ((k == 2) ? ADDU312 : '0), 1'b0, 1'b1);
    cyc("div c11", 1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("div delta", STALL_CNT - base, 32'd0);

    // Reset in the middle of a div busy window with an MDU op stalled in ID.
    cyc("rdiv c0", 1'b0, '0,   DIV, '0,  1'b0, 1'b1);
    cyc("rdiv c1", 1'b0, MTHI, '0,  DIV, 1'b1, 1'b1);
    cyc("rdiv c2", 1'b0, MTHI, '0,  '0,  1'b1, 1'b1);
    cyc("rdiv rst0", 1'b1, MTHI, '0, '0, 1'b0, 1'b1);
    cyc("rdiv rst1", 1'b1, MTHI, '0, '0, 1'b0, 1'b0);
    cyc("rdiv run", 1'b0, MTHI, '0, '0, 1'b0, 1'b0);
    chk("rdiv cnt", STALL_CNT, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
